buzzer_arbiter: RTL
===================

Name: buzzer_arbiter

Overview:
- Shares the single tone generator (note code → divider preset → square wave → buzzer pin) among three requesters: alarm, key-click beep, song player.
- Grants one requester at a time by fixed priority and latches its note code and duration.
- Times the note in millisecond ticks derived from sys_clk, then inserts a silent gap.
- Sits between the requesters and the tone generator; drives the generator's 12-bit note code {high,med,low} and an enable.

Parameters:
- CLK_HZ, 100000000, sys_clk frequency.
- TICK_HZ, 1000, duration tick rate. TICK_DIV = CLK_HZ/TICK_HZ and must be ≥2.
- GAP_TICKS, 20, silent ticks inserted after every completed note. 0 means no gap.
- DUR_W, 10, width of duration fields in ticks.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  3  per-requester valid. Bit0 song, bit1 key, bit2 alarm.
- req_note  in  36  three 12-bit note codes, requester i at [12i+11:12i]. Nibbles are {high,med,low}; 12'h000 is rest.
- req_dur  in  3*DUR_W  per-requester duration in ticks.
- req_ready  out  3  accept strobe. Combinational; transfer occurs on valid&ready.
- note_out  out  12  note code to tone generator. Registered.
- tone_en  out  1  high while a non-rest note is playing.
- grant  out  3  one-hot owner of the generator, 0 when idle.
- done  out  3  one-cycle pulse per requester when its note completes normally.
- abort  out  3  one-cycle pulse per requester when its note is preempted.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, PLAY, GAP. Reset → IDLE. All outputs 0 after reset, including note_out = 12'h000. Prescaler and counters are cleared.
- Priority: alarm > key > song. req_ready asserts only for the single highest-priority valid requester, in these cases:
  - state IDLE;
  - state GAP on its final cycle;
  - state PLAY, when that requester strictly outranks the current grant (preemption).
- Accept at edge N:
  - latch note and dur;
  - set grant;
  - clear the prescaler and tick counter;
  - enter PLAY.
- From N+1: note_out = latched note; tone_en = (note != 0).
- dur = 0: the request is accepted, done pulses at N+1, and the state goes directly to GAP (or IDLE if GAP_TICKS = 0). note_out and tone_en stay 0.
- PLAY:
  - The prescaler counts 0..TICK_DIV-1, and the tick counter increments on wrap.
  - PLAY lasts exactly dur*TICK_DIV cycles.
  - On the last cycle: done[grant] pulses on the next cycle; tone_en and note_out go to 0; grant goes to 0; state becomes GAP (IDLE if GAP_TICKS = 0).
- Rest note (12'h000): timed identically, but tone_en stays 0.
- GAP: lasts GAP_TICKS*TICK_DIV cycles with tone_en = 0 and grant = 0, then IDLE. An accept on the final GAP cycle goes straight to PLAY with no idle cycle.
- Preemption in PLAY: a strictly higher requester valid triggers an accept on the same edge.
  - abort[old] pulses one cycle after.
  - The new note is latched and its timing restarts; no gap is inserted.
  - Equal or lower priority never preempts. It waits for IDLE, or for the final GAP cycle when it is the top requester there.
- A new valid arriving during GAP is not accepted until the final GAP cycle.
- done and abort never pulse together for the same requester. A done and an accept on the same edge are legal.
- Requesters must hold valid, note and dur until ready. Changes while waiting are sampled only at accept.
- Reset mid-PLAY or mid-GAP: next cycle all outputs are 0, state is IDLE, and no done or abort pulse is emitted.
- Counters: the tick counter is DUR_W bits wide and compares against the latched dur, so there is no wrap, since dur ≤ 2^DUR_W - 1. The prescaler is ceil(log2(TICK_DIV)) bits.

Decomposition:
- Package buzzer_pkg holds:
  - requester index constants REQ_SONG=0, REQ_KEY=1, REQ_ALARM=2;
  - NOTE_REST=12'h000;
  - the state encoding {IDLE, PLAY, GAP}.
- Sub-module tick_prescaler (parameter TICK_DIV; inputs sys_clk, rst, clr; output tick) is shared with the score sequencer.
- The priority encoder stays inline.

Test Plan (CLK_HZ=1000, TICK_HZ=100 → TICK_DIV=10, GAP_TICKS=2):
- Song only, note 12'h005, dur 3, accepted at cycle 0 → ready pulse at cycle 0; note_out=12'h005 and tone_en=1 for cycles 1..30; done[0] pulses once; busy drops 20 cycles after PLAY ends.
- Key (12'h010, dur 2) and song valid together in IDLE → only req_ready[1] is asserted; grant=3'b010; song is accepted on the final GAP cycle and enters PLAY with no idle cycle.
- Song playing dur 50; alarm (12'h300, dur 4) raised at cycle 100 → accepted the same edge; abort[0] pulses; note_out=12'h300 for 40 cycles; done[2] pulses; done[0] never pulses.
- Key playing; song raises valid → no preemption; key runs to completion; song waits through the gap.
- Rest note 12'h000, dur 2 → grant and busy assert and PLAY lasts 20 cycles; tone_en=0 throughout; done pulses. Then dur 0 → done pulses at N+1 and tone_en never asserts.
- rst asserted mid-PLAY → next cycle all outputs 0 and state IDLE; no done or abort pulse. A new request after reset is timed from a cleared prescaler.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer arbiter: requester indices, the rest note
// code and the arbiter state encoding.
package buzzer_pkg;

   localparam int REQ_SONG  = 0;
   localparam int REQ_KEY   = 1;
   localparam int REQ_ALARM = 2;

   localparam logic [11:0] NOTE_REST = 12'h000;

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      GAP
   } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides sys_clk down to a one-cycle tick every TICK_DIV cycles; clr restarts
// the count so the first tick lands exactly TICK_DIV cycles after the clear.
module tick_prescaler #(
   parameter int TICK_DIV = 10
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge sys_clk) begin
      if (rst || clr || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority arbiter sharing one tone generator between alarm, key-click
// and song requesters; times each note in ticks and follows it with a silent gap.
module buzzer_arbiter
   import buzzer_pkg::*;
#(
   parameter int CLK_HZ    = 100000000,
   parameter int TICK_HZ   = 1000,
   parameter int GAP_TICKS = 20,
   parameter int DUR_W     = 10
) (
   input  logic               sys_clk,
   input  logic               rst,
   input  logic [2:0]         req_valid,
   input  logic [35:0]        req_note,
   input  logic [3*DUR_W-1:0] req_dur,
   output logic [2:0]         req_ready,
   output logic [11:0]        note_out,
   output logic               tone_en,
   output logic [2:0]         grant,
   output logic [2:0]         done,
   output logic [2:0]         abort,
   output logic               busy
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_TICKS - 1);
   localparam state_t AFTER_NOTE = (GAP_TICKS == 0) ? IDLE : GAP;

   state_t state, state_nx;

   logic [2:0]       top;
   logic [11:0]      sel_note;
   logic [DUR_W-1:0] sel_dur;
   logic [DUR_W-1:0] dur_q;
   logic [DUR_W-1:0] tick_cnt;
   logic             tick;
   logic             pre_clr;
   logic             accept;
   logic             play_last;
   logic             gap_last;

   always_comb begin
      top      = '0;
      sel_note = NOTE_REST;
      sel_dur  = '0;
      if (req_valid[REQ_ALARM]) begin
         top[REQ_ALARM] = 1'b1;
         sel_note       = req_note[12*REQ_ALARM +: 12];
         sel_dur        = req_dur[DUR_W*REQ_ALARM +: DUR_W];
      end else if (req_valid[REQ_KEY]) begin
         top[REQ_KEY] = 1'b1;
         sel_note     = req_note[12*REQ_KEY +: 12];
         sel_dur      = req_dur[DUR_W*REQ_KEY +: DUR_W];
      end else if (req_valid[REQ_SONG]) begin
         top[REQ_SONG] = 1'b1;
         sel_note      = req_note[12*REQ_SONG +: 12];
         sel_dur       = req_dur[DUR_W*REQ_SONG +: DUR_W];
      end
   end

   assign play_last = (state == PLAY) && tick && (tick_cnt == dur_q - 1'b1);
   assign gap_last  = (state == GAP) && tick && (tick_cnt == GAP_LAST);
   assign accept    = |req_ready;
   assign pre_clr   = accept || play_last || (state == IDLE);
   assign busy      = (state != IDLE);

   tick_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_prescaler (
      .sys_clk(sys_clk),
      .rst    (rst),
      .clr    (pre_clr),
      .tick   (tick)
   );

   always_ff @(posedge sys_clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Both grant and top are one-hot with the alarm in the top bit, so a plain
   // magnitude compare means "strictly outranks".
   always_comb begin
      state_nx  = state;
      req_ready = '0;
      case (state)
         IDLE:    req_ready = top;
         PLAY:    if (top > grant) req_ready = top;
         GAP:     if (gap_last) req_ready = top;
         default: req_ready = '0;
      endcase
      if (accept)
         state_nx = (sel_dur == '0) ? AFTER_NOTE : PLAY;
      else if (play_last)
         state_nx = AFTER_NOTE;
      else if (gap_last)
         state_nx = IDLE;
   end

   always_ff @(posedge sys_clk) begin
      if (rst || pre_clr)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= tick_cnt + 1'b1;
   end

   // A preempting accept reports the outgoing owner as aborted even when it
   // lands on that owner's final cycle; a zero-length note completes at once.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         dur_q    <= '0;
         note_out <= NOTE_REST;
         tone_en  <= 1'b0;
         grant    <= '0;
         done     <= '0;
         abort    <= '0;
      end else begin
         done  <= '0;
         abort <= '0;
         if (accept) begin
            dur_q <= sel_dur;
            if (state == PLAY)
               abort <= grant;
            if (sel_dur == '0) begin
               done     <= req_ready;
               note_out <= NOTE_REST;
               tone_en  <= 1'b0;
               grant    <= '0;
            end else begin
               note_out <= sel_note;
               tone_en  <= (sel_note != NOTE_REST);
               grant    <= req_ready;
            end
         end else if (play_last) begin
            done     <= grant;
            note_out <= NOTE_REST;
            tone_en  <= 1'b0;
            grant    <= '0;
         end
      end
   end

endmodule
